// File: rtl/arith_pkg.sv
// Shared constants and state encoding for the sequential divider.
// N is the quotient/remainder width; the dividend is 2N wide.
package arith_pkg;
  localparam int N  = 16;
  localparam int CW = 4;
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_divider_32_16_div_step.sv
// One restoring-division iteration.
// Shifts the next dividend bit into the partial remainder, then keeps the
// trial difference only when it does not go negative.
module div_step
  import arith_pkg::*;
(
  input  logic [N:0]   r,
  input  logic [N-1:0] q,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_next,
  output logic [N-1:0] q_next
);
  logic [N:0] shifted;
  logic [N:0] trial;
  // The partial remainder stays below the divisor, so its top bit is always 0.
  logic       unused_r_msb;

  assign unused_r_msb = r[N];

  always_comb begin
    shifted = {r[N-1:0], q[N-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[N]) begin
      r_next = trial;
      q_next = {q[N-2:0], 1'b1};
    end else begin
      r_next = shifted;
      q_next = {q[N-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/seq_divider_32_16.sv
// Multi-cycle restoring divider: 32-bit dividend / 16-bit divisor.
// Produces one quotient bit per clock, with a start/busy/done handshake.
module seq_divider_32_16
  import arith_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     r_q, r_d;
  logic [N-1:0]   qw_q, qw_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;
  logic [N:0]     r_next;
  logic [N-1:0]   q_next;

  div_step u_step (
    .r       (r_q),
    .q       (qw_q),
    .divisor (dvs_q),
    .r_next  (r_next),
    .q_next  (q_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    qw_d    = qw_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend[N-1:0];
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else if (dividend[2*N-1:N] >= divisor) begin
            // Quotient would not fit in N bits.
            quo_d   = '1;
            rem_d   = dividend[2*N-1:N];
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            r_d     = {1'b0, dividend[2*N-1:N]};
            qw_d    = dividend[N-1:0];
            dvs_d   = divisor;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d   = r_next;
        qw_d  = q_next;
        cnt_d = cnt_q + CW'(1);
        // Visible results only change when the last bit lands.
        if (cnt_q == LAST_ITER) begin
          quo_d   = q_next;
          rem_d   = r_next[N-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      qw_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      qw_q    <= qw_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider_32_16.sv
// Self-checking bench for seq_divider_32_16: directed vector table,
// handshake corner sequences, and random operations against an arithmetic model.
module tb_seq_divider_32_16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy, done, div_by_zero, overflow;
  logic [15:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_divider_32_16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    logic [31:0] dd;
    logic [15:0] dv;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          bsy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference from plain division rules.
  task automatic model(input logic [31:0] dd, input logic [15:0] dv,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dbz, output logic ovf);
    dbz = 1'b0; ovf = 1'b0;
    if (dv == 0) begin
      q = 16'hFFFF; r = dd[15:0]; dbz = 1'b1;
    end else if (dd[31:16] >= dv) begin
      q = 16'hFFFF; r = dd[31:16]; ovf = 1'b1;
    end else begin
      q = 16'(dd / {16'd0, dv});
      r = 16'(dd % {16'd0, dv});
    end
  endtask

  // Drive start for one edge; returns at the negedge after acceptance.
  task automatic issue(input logic [31:0] dd, input logic [15:0] dv);
    start = 1'b1; dividend = dd; divisor = dv;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = 16'($urandom);
  endtask

  // Called at negedge number lat0 after acceptance; counts until done.
  task automatic wait_done(input int lat0, input int bsy0, output int lat, output int bsy);
    lat = lat0; bsy = bsy0;
    while (!done && lat < 40) begin
      if (busy) bsy++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL timeout: no done after %0d cycles", lat);
    end
  endtask

  task automatic chk_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                            input logic dbz, input logic ovf);
    chk({tag, ".quotient"}, 32'(quotient), 32'(q));
    chk({tag, ".remainder"}, 32'(remainder), 32'(r));
    chk({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(dbz));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  vec_t vecs[6];

  initial begin
    int lat, bsy;
    logic [15:0] eq, er;
    logic edbz, eovf;

    vecs[0] = '{32'h000186A0, 16'd7,     16'h37CD, 16'd5,     1'b0, 1'b0, 17, 16};
    vecs[1] = '{32'hFFFE0001, 16'hFFFF,  16'hFFFF, 16'd0,     1'b0, 1'b0, 17, 16};
    vecs[2] = '{32'h00070000, 16'd7,     16'hFFFF, 16'h0007,  1'b0, 1'b1, 1,  0};
    vecs[3] = '{32'h1234ABCD, 16'd0,     16'hFFFF, 16'hABCD,  1'b1, 1'b0, 1,  0};
    vecs[4] = '{32'd9,        16'd2,     16'd4,    16'd1,     1'b0, 1'b0, 17, 16};
    vecs[5] = '{32'h0000FFFF, 16'd1,     16'hFFFF, 16'd0,     1'b0, 1'b0, 17, 16};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    @(negedge clk); @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk_result("reset", 16'd0, 16'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].dd, vecs[i].dv);
      wait_done(1, 0, lat, bsy);
      chk($sformatf("vec%0d.latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d.busy_cycles", i), 32'(bsy), 32'(vecs[i].bsy));
      chk_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf);
      @(negedge clk);
      chk($sformatf("vec%0d.done_width", i), 32'(done), 32'd0);
      chk_result($sformatf("vec%0d.hold", i), vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf);
    end

    // Start while busy is ignored; start in DONE cycle is accepted.
    issue(32'd100000, 16'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, 5, lat, bsy);
    chk("busystart.latency", 32'(lat), 32'd17);
    chk_result("busystart", 16'd14285, 16'd5, 1'b0, 1'b0);
    issue(32'd50, 16'd5);
    chk("b2b.done_drop", 32'(done), 32'd0);
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.hold_q", 32'(quotient), 32'd14285);
    wait_done(1, 0, lat, bsy);
    chk("b2b.latency", 32'(lat), 32'd17);
    chk_result("b2b", 16'd10, 16'd0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset mid-calculation.
    issue(32'd100000, 16'd7);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk_result("midrst", 16'd0, 16'd0, 1'b0, 1'b0);
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      chk("midrst.no_done", 32'(seen), 32'd0);
    end
    issue(32'd9, 16'd2);
    wait_done(1, 0, lat, bsy);
    chk_result("midrst.after", 16'd4, 16'd1, 1'b0, 1'b0);
    @(negedge clk);

    // Random legal operations against the model.
    begin
      int rfail = 0;
      for (int n = 0; n < 1000; n++) begin
        logic [31:0] dd;
        logic [15:0] dv;
        dv = 16'($urandom_range(1, 65535));
        dd = {16'($urandom_range(0, int'(dv) - 1)), 16'($urandom)};
        model(dd, dv, eq, er, edbz, eovf);
        issue(dd, dv);
        wait_done(1, 0, lat, bsy);
        if (quotient !== eq || remainder !== er || div_by_zero !== edbz ||
            overflow !== eovf || lat != 17 ||
            ({16'd0, quotient} * {16'd0, dv} + {16'd0, remainder}) != dd ||
            remainder >= dv) begin
          rfail++;
          if (rfail <= 5)
            $display("FAIL random %0h/%0h: got q=%0h r=%0h lat=%0d expected q=%0h r=%0h",
                     dd, dv, quotient, remainder, lat, eq, er);
        end
        @(negedge clk);
        if (done) begin
          rfail++;
          if (rfail <= 5) $display("FAIL random.done_width %0h/%0h: got done=1 expected 0", dd, dv);
        end
      end
      chk("random.mismatches", 32'(rfail), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_divider_32_16.md
Name: seq_divider_32_16

Overview:
- Multi-cycle restoring divider: 32-bit dividend / 16-bit divisor -> 16-bit quotient and 16-bit remainder.
- Inverse companion of the upper-half placement / multiply path in the HW4 arithmetic unit. It unpacks a 32-bit product-width value back into 16-bit quotient and remainder halves.
- Produces one quotient bit per clock. Start/busy/done handshake toward the ALU control FSM.

Parameters:
- N, 16, operand half-width. Dividend is 2N, divisor/quotient/remainder are N. Only N=16 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  request; sampled only when state != CALC
- dividend  input  32  sampled with accepted start
- divisor  input  16  sampled with accepted start
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse, results valid
- quotient  output  16  held from done until next accepted start
- remainder  output  16  held likewise
- div_by_zero  output  1  sticky with results; divisor was 0
- overflow  output  1  sticky with results; dividend[31:16] >= divisor, divisor != 0

Behaviour:
- Reset: rst_n=0 at a rising edge forces state=IDLE. All outputs go to 0: busy, done, quotient, remainder, div_by_zero, overflow. The iteration counter clears. Reset has priority over everything, including mid-CALC; no partial result is exposed.
- FSM states:
  - IDLE: start=1 -> check operands.
  - CALC: 16 iterations. Counter 0..15; at count=15 -> DONE.
  - DONE: done=1 for exactly this cycle. Next edge -> IDLE, or accept a new start (same rules as IDLE).
- Start accepted (edge k, state IDLE or DONE):
  - divisor==0: results Q=16'hFFFF, R=dividend[15:0], div_by_zero=1. -> DONE, so done is high in cycle k+1.
  - else dividend[31:16] >= divisor: Q=16'hFFFF, R=dividend[31:16], overflow=1. -> DONE, done in cycle k+1.
  - else: R_reg(17b)={0,dividend[31:16]}, Q_reg=dividend[15:0], flags cleared, counter=0. -> CALC; busy=1 from cycle k+1.
- Normal-path outputs: quotient and remainder are driven from Q_reg and R_reg[15:0] only in DONE and afterwards. During CALC they hold the previous result.
- CALC iteration (each edge):
  - shifted = {R_reg[15:0], Q_reg[15]}, 17 bits.
  - trial = shifted - {1'b0, divisor}, 17-bit subtract.
  - If trial[16]==0: R_reg=trial, Q_reg={Q_reg[14:0],1}. Else: R_reg=shifted, Q_reg={Q_reg[14:0],0}.
- Latency: normal path, done high in cycle k+17 (16 iterations at edges k+1..k+16). Error paths, k+1.
- start while busy (CALC): ignored. No queueing, and operands are not resampled.
- start in the DONE cycle: accepted. done drops next cycle; back-to-back throughput is 17 cycles.
- Invariant on normal completion: dividend == quotient*divisor + remainder, remainder < divisor.
- Exactly one of {normal, div_by_zero, overflow} per operation. Flags are never both 1.

Decomposition:
- Shared package arith_pkg:
  - State encoding localparams IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Width constant N=16 and iteration-count width 4.
- One combinational sub-module, div_step: inputs R(17), Q(16), divisor(16); outputs R_next, Q_next. It holds the shift/trial-subtract/select logic. The top keeps the FSM, counter, operand checks, and output registers.

Test Plan:
- dividend=32'h000186A0 (100000), divisor=7 -> done at k+17; quotient=16'h37CD (14285), remainder=5, flags 0; busy high exactly 16 cycles.
- dividend=32'hFFFE0001, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=0, overflow=0 (max legal case).
- dividend=32'h00070000, divisor=7 -> done at k+1; overflow=1, quotient=16'hFFFF, remainder=16'h0007. Also divisor=0, dividend=32'h1234ABCD -> div_by_zero=1, quotient=16'hFFFF, remainder=16'hABCD.
- start 100000/7, then start=1 with 50/5 at cycle k+5 -> ignored; result still 14285 r 5. Then start 50/5 in the DONE cycle -> accepted, quotient=10, remainder=0 at +17.
- start 100000/7, rst_n=0 at cycle k+8 for one edge -> all outputs 0, state IDLE, no done pulse. A subsequent 9/2 gives quotient=4, remainder=1.
- Random 1000 operations with divisor!=0 and dividend[31:16]<divisor -> the invariant holds; done is always one cycle wide.
